// File: rtl/jam_perm_engine.sv
// jam_perm_engine: exhaustive job-assignment search over all N! permutations,
// reporting the minimum total cost and how many permutations reach it.
module jam_perm_engine #(
  parameter int N = 8,
  parameter int CW = 7,
  parameter int MCW = 4,
  parameter int AUTO_START = 1,
  localparam int IW = ($clog2(N) < 1) ? 1 : $clog2(N),
  localparam int SW = CW + IW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           prune,
  output logic [IW-1:0]  w,
  output logic [IW-1:0]  j,
  input  logic [CW-1:0]  cost,
  output logic           busy,
  output logic [MCW-1:0] match_count,
  output logic [SW-1:0]  min_cost,
  output logic           valid
);
  typedef enum logic [1:0] {IDLE, ACC, STEP, DONE} state_t;
  state_t state, nstate;
  logic [IW-1:0] perm [N];
  logic [IW-1:0] sw_p [N];
  logic [IW-1:0] nxt [N];
  logic [IW-1:0] k, piv, suc;
  logic [SW-1:0] acc, sum;
  logic prune_l, pruned, auto_pend, go, last_k, cut, has_piv;

  assign go = start || auto_pend;
  assign sum = acc + SW'(cost);
  assign last_k = k == IW'(N - 1);
  // strict '>' keeps ties alive so the match count stays exact
  assign cut = prune_l && (sum > min_cost) && !last_k;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nstate;

  always_comb begin
    nstate = state;
    case (state)
      IDLE: nstate = go ? ACC : IDLE;
      ACC: nstate = (cut || last_k) ? STEP : ACC;
      STEP: nstate = has_piv ? ACC : DONE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ACC) || (state == STEP);
    valid = state == DONE;
    w = (state == ACC) ? k : '0;
    j = (state == ACC) ? perm[k] : '0;
  end

  // next lexicographic permutation: pivot, successor, swap, reverse suffix
  always_comb begin
    piv = '0;
    has_piv = 1'b0;
    for (int i = 0; i < N - 1; i++)
      if (perm[i] < perm[i+1]) begin
        piv = IW'(i);
        has_piv = 1'b1;
      end
    suc = '0;
    for (int i = 0; i < N; i++)
      if (IW'(i) > piv && perm[i] > perm[piv]) suc = IW'(i);
    sw_p = perm;
    sw_p[piv] = perm[suc];
    sw_p[suc] = perm[piv];
    for (int i = 0; i < N; i++)
      nxt[i] = (IW'(i) > piv) ? sw_p[IW'(N) + piv - IW'(i)] : sw_p[i];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) perm[i] <= IW'(i);
      k <= '0;
      acc <= '0;
      min_cost <= '1;
      match_count <= '0;
      prune_l <= 1'b0;
      pruned <= 1'b0;
      auto_pend <= AUTO_START != 0;
    end else begin
      case (state)
        IDLE:
          if (go) begin
            for (int i = 0; i < N; i++) perm[i] <= IW'(i);
            k <= '0;
            acc <= '0;
            min_cost <= '1;
            match_count <= '0;
            prune_l <= prune;
            pruned <= 1'b0;
            auto_pend <= 1'b0;
          end
        ACC: begin
          pruned <= cut;
          if (!cut) acc <= sum;
          k <= k + 1'b1;
        end
        STEP: begin
          if (!pruned && acc < min_cost) begin
            min_cost <= acc;
            match_count <= MCW'(1);
          end else if (!pruned && acc == min_cost && match_count != '1)
            match_count <= match_count + 1'b1;
          perm <= nxt;
          acc <= '0;
          k <= '0;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_jam_perm_engine.sv
// tb_jam_perm_engine: scoreboard bench over N=2 (auto-start), 3, 4 and 5 engines.
module tb_jam_perm_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0] cm [4][8][8];
  logic st [4];
  logic pr [4];
  logic bz [4];
  logic vv [4];
  int vc [4];
  int vcy [4];
  int q [4][$];

  logic       w2, j2;
  logic [6:0] cost2, cost3, cost4, cost5;
  logic [1:0] w3, j3, w4, j4;
  logic [2:0] w5, j5;
  logic [3:0] mc2, mc3, mc4, mc5;
  logic [7:0] mn2;
  logic [8:0] mn3, mn4;
  logic [9:0] mn5;

  assign cost2 = cm[0][3'(w2)][3'(j2)];
  assign cost3 = cm[1][3'(w3)][3'(j3)];
  assign cost4 = cm[2][3'(w4)][3'(j4)];
  assign cost5 = cm[3][w5][j5];

  jam_perm_engine #(.N(2), .CW(7), .MCW(4), .AUTO_START(1)) u2 (
    .clk(clk), .rst_n(rst2_n), .start(st[0]), .prune(pr[0]), .w(w2), .j(j2), .cost(cost2),
    .busy(bz[0]), .match_count(mc2), .min_cost(mn2), .valid(vv[0]));
  jam_perm_engine #(.N(3), .CW(7), .MCW(4), .AUTO_START(0)) u3 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .prune(pr[1]), .w(w3), .j(j3), .cost(cost3),
    .busy(bz[1]), .match_count(mc3), .min_cost(mn3), .valid(vv[1]));
  jam_perm_engine #(.N(4), .CW(7), .MCW(4), .AUTO_START(0)) u4 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .prune(pr[2]), .w(w4), .j(j4), .cost(cost4),
    .busy(bz[2]), .match_count(mc4), .min_cost(mn4), .valid(vv[2]));
  jam_perm_engine #(.N(5), .CW(7), .MCW(4), .AUTO_START(0)) u5 (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .prune(pr[3]), .w(w5), .j(j5), .cost(cost5),
    .busy(bz[3]), .match_count(mc5), .min_cost(mn5), .valid(vv[3]));

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic mon(int id, logic v, int mn, int mc);
    int e;
    if (!v) return;
    vc[id]++;
    vcy[id] = cyc;
    if (q[id].size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_valid u%0d got min=%0d count=%0d want no result", id, mn, mc);
    end else begin
      e = q[id].pop_front();
      chk($sformatf("min_cost_u%0d", id), mn, e / 256);
      chk($sformatf("match_count_u%0d", id), mc, e % 256);
    end
  endtask

  always @(negedge clk) begin
    mon(0, vv[0], int'(mn2), int'(mc2));
    mon(1, vv[1], int'(mn3), int'(mc3));
    mon(2, vv[2], int'(mn4), int'(mc4));
    mon(3, vv[3], int'(mn5), int'(mc5));
  end

  task automatic run(int id, bit p, int emn, int emc, output int lat);
    int n0, s, t;
    q[id].push_back(emn * 256 + emc);
    n0 = vc[id];
    @(negedge clk);
    st[id] = 1'b1;
    pr[id] = p;
    @(posedge clk);
    #1 s = cyc;
    @(negedge clk);
    st[id] = 1'b0;
    pr[id] = 1'b0;
    t = 0;
    while (vc[id] == n0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (vc[id] == n0) begin
      checks++;
      errors++;
      $display("FAIL timeout u%0d no valid after %0d cycles", id, t);
      lat = -1;
      return;
    end
    lat = vcy[id] - s + 1;
    repeat (30) @(posedge clk);
    chk("single_valid", vc[id] - n0, 1);
    chk("busy_after_done", int'(bz[id]), 0);
  endtask

  task automatic golden(output int mn, output int mc);
    int s;
    mn = 1 << 30;
    mc = 0;
    for (int a = 0; a < 5; a++)
      for (int b = 0; b < 5; b++)
        for (int c = 0; c < 5; c++)
          for (int d = 0; d < 5; d++)
            for (int e = 0; e < 5; e++)
              if (((1 << a) | (1 << b) | (1 << c) | (1 << d) | (1 << e)) == 31) begin
                s = int'(cm[3][0][a]) + int'(cm[3][1][b]) + int'(cm[3][2][c]) +
                    int'(cm[3][3][d]) + int'(cm[3][4][e]);
                if (s < mn) begin
                  mn = s;
                  mc = 1;
                end else if (s == mn) mc++;
              end
    if (mc > 15) mc = 15;
  endtask

  task automatic fill5(int r);
    for (int a = 0; a < 5; a++)
      for (int b = 0; b < 5; b++)
        cm[3][a][b] = (r % 2 == 1) ? 7'($urandom_range(0, 3)) : 7'($urandom_range(0, 127));
  endtask

  initial begin
    int lat, lat_np, lat_p, s, gmn, gmc;
    bit p;
    for (int i = 0; i < 4; i++) begin
      st[i] = 1'b0;
      pr[i] = 1'b0;
      vc[i] = 0;
      vcy[i] = 0;
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++) cm[i][a][b] = 7'd0;
    end
    cm[0][0][0] = 7'd5; cm[0][0][1] = 7'd1; cm[0][1][0] = 7'd2; cm[0][1][1] = 7'd7;
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++) cm[1][a][b] = 7'(3 * a + b);
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) cm[2][a][b] = (a == b) ? 7'd0 : 7'd10;
    for (int a = 0; a < 5; a++)
      for (int b = 0; b < 5; b++) cm[3][a][b] = 7'd1;
    q[0].push_back(3 * 256 + 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_min_cost", int'(mn3), 511);
    chk("rst_match_count", int'(mc3), 0);
    chk("rst_busy", int'(bz[1]), 0);
    chk("rst_valid", int'(vv[1]), 0);
    chk("rst_w", int'(w3), 0);
    chk("rst_j", int'(j3), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rst2_n = 1'b1;
    @(posedge clk);
    #1 s = cyc;
    for (int i = 0; i < 50 && vc[0] == 0; i++) @(posedge clk);
    chk("auto_valid_count", vc[0], 1);
    chk("auto_latency", vcy[0] - s + 1, 7);
    repeat (20) @(posedge clk);
    chk("auto_once", vc[0], 1);
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++) cm[0][a][b] = 7'd4;
    run(0, 1'b0, 8, 2, lat);
    chk("n2_latency", lat, 7);
    run(1, 1'b0, 12, 6, lat);
    chk("t1_latency", lat, 25);
    run(1, 1'b1, 12, 6, lat);
    chk("t1_prune_ties_latency", lat, 25);
    run(2, 1'b0, 0, 1, lat_np);
    chk("t2_latency", lat_np, 121);
    run(2, 1'b1, 0, 1, lat_p);
    chk("t2_prune_earlier", int'(lat_p > 0 && lat_p < lat_np), 1);
    run(3, 1'b0, 5, 15, lat);
    chk("t3_latency", lat, 721);
    fork
      begin
        int s0;
        for (int i = 0; i < 20 && !bz[1]; i++) @(negedge clk);
        s0 = cyc;
        while (cyc < s0 + 4) @(negedge clk);
        st[1] = 1'b1;
        @(negedge clk);
        st[1] = 1'b0;
        while (cyc < s0 + 24) @(negedge clk);
        st[1] = 1'b1;
        @(negedge clk);
        st[1] = 1'b0;
      end
    join_none
    run(1, 1'b0, 12, 6, lat);
    chk("t6_latency", lat, 25);
    fill5(0);
    @(negedge clk);
    st[3] = 1'b1;
    @(negedge clk);
    st[3] = 1'b0;
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_min_cost", int'(mn5), 1023);
    chk("abort_match_count", int'(mc5), 0);
    chk("abort_busy", int'(bz[3]), 0);
    chk("abort_valid", int'(vv[3]), 0);
    chk("abort_w", int'(w5), 0);
    chk("abort_j", int'(j5), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    golden(gmn, gmc);
    run(3, 1'b0, gmn, gmc, lat);
    chk("t5_latency", lat, 721);
    for (int r = 0; r < 20; r++) begin
      fill5(r);
      golden(gmn, gmc);
      p = 1'($urandom_range(0, 1));
      run(3, p, gmn, gmc, lat);
      if (p) chk("t4_prune_bound", int'(lat > 0 && lat <= 721), 1);
      else chk("t4_latency", lat, 721);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("queue_drained_u%0d", i), q[i].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
